// File: rtl/alu_pkg.sv
// Shared ALU operation codes and datapath widths for the execute/write-back stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic alu_code_legal(input logic [2:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file: two operand read ports, one debug read port, ALU and loader write ports.
// Register 0 is hard zero; the ALU write wins when both ports target the same register.
module reg_file_2r1w
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              alu_we,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] regs [NREGS];

    logic alu_commit;
    logic ld_commit;

    assign alu_commit = alu_we && (alu_addr != '0);
    assign ld_commit  = ld_we && (ld_addr != '0) && !(alu_commit && (alu_addr == ld_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_commit) begin
                regs[ld_addr] <= ld_data;
            end
            if (alu_commit) begin
                regs[alu_addr] <= alu_data;
            end
        end
    end

    // Register 0 is never written, but the explicit zero keeps reads independent of that.
    assign ra_data  = (ra_addr == '0)  ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr == '0)  ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_regfile_exec.sv
// Execute/write-back stage: reads rs/rt, runs the ALU, writes rd at the edge,
// and registers the result, flags and a retired-instruction count.
module alu_regfile_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [AW-1:0]     rs,
    input  logic [AW-1:0]     rt,
    input  logic [AW-1:0]     rd,
    input  logic [2:0]        ALU_ctrl,
    input  logic              reg_write,
    input  logic              init_we,
    input  logic [AW-1:0]     init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] result_q,
    output logic              zero_q,
    output logic              illegal_q,
    output logic              result_valid,
    output logic [31:0]       retired_cnt
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_illegal;
    logic              wb_en;

    reg_file_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (rs),
        .ra_data  (op_a),
        .rb_addr  (rt),
        .rb_data  (op_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .alu_we   (wb_en),
        .alu_addr (rd),
        .alu_data (alu_result),
        .ld_we    (init_we),
        .ld_addr  (init_addr),
        .ld_data  (init_data)
    );

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (ALU_ctrl)
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_illegal = 1'b1;
        endcase
    end

    // rd==0 is filtered inside the register file; reset blocks the write there too.
    assign wb_en = instr_valid && reg_write && !alu_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            result_valid <= 1'b0;
            retired_cnt  <= '0;
        end else if (instr_valid) begin
            result_q     <= alu_result;
            zero_q       <= (alu_result == '0);
            illegal_q    <= alu_illegal;
            result_valid <= 1'b1;
            retired_cnt  <= retired_cnt + 32'd1;
        end else begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_regfile_exec.sv
// Bench for alu_regfile_exec: directed vector table, reset-in-flight sequence,
// then randomized traffic against an array-based reference model.
module tb_alu_regfile_exec;

    localparam logic [2:0] T_AND = 3'b000;
    localparam logic [2:0] T_OR  = 3'b001;
    localparam logic [2:0] T_ADD = 3'b010;
    localparam logic [2:0] T_SUB = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;
    localparam logic [2:0] T_BAD = 3'b100;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  ALU_ctrl;
    logic        reg_write;
    logic        init_we;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] result_q;
    logic        zero_q;
    logic        illegal_q;
    logic        result_valid;
    logic [31:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    alu_regfile_exec dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .ALU_ctrl     (ALU_ctrl),
        .reg_write    (reg_write),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .result_q     (result_q),
        .zero_q       (zero_q),
        .illegal_q    (illegal_q),
        .result_valid (result_valid),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  ctrl;
        logic        rw;
        logic        lwe;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  da;
        logic [31:0] e_res;
        logic        e_z, e_ill, e_v;
        logic [31:0] e_dbg;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic iv, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic [2:0] c, input logic rw,
                                input logic lwe, input logic [4:0] la, input logic [31:0] ld,
                                input logic [4:0] da, input logic [31:0] er, input logic ez,
                                input logic ei, input logic ev, input logic [31:0] edbg,
                                input logic [31:0] ecnt);
        vec_t v;
        v.iv = iv; v.rs = a; v.rt = b; v.rd = d; v.ctrl = c; v.rw = rw;
        v.lwe = lwe; v.la = la; v.ld = ld; v.da = da;
        v.e_res = er; v.e_z = ez; v.e_ill = ei; v.e_v = ev; v.e_dbg = edbg; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: plain array of register contents plus observed outputs.
    logic [31:0] m_regs [32];
    logic [31:0] m_res;
    logic        m_zero, m_ill, m_valid;
    logic [31:0] m_cnt;

    function automatic void ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ill = 1'b0;
        case (c)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            3'd6:    r = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            3'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_res = 0; m_zero = 0; m_ill = 0; m_valid = 0; m_cnt = 0;
    endfunction

    task automatic model_edge();
        logic [31:0] a, b, r;
        logic        ill;
        if (reset) begin
            model_reset();
            return;
        end
        a = m_regs[rs];
        b = m_regs[rt];
        ref_alu(ALU_ctrl, a, b, r, ill);
        if (init_we && init_addr != 0) m_regs[init_addr] = init_data;
        if (instr_valid && reg_write && !ill && rd != 0) m_regs[rd] = r;
        if (instr_valid) begin
            m_res = r; m_zero = (r == 0); m_ill = ill; m_valid = 1; m_cnt = m_cnt + 1;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic idle_inputs();
        instr_valid = 0; rs = 0; rt = 0; rd = 0; ALU_ctrl = T_ADD; reg_write = 0;
        init_we = 0; init_addr = 0; init_data = 0; dbg_addr = 0;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0, 0,  T_ADD, 0, 1, 1,  32'd7,        1,  32'd0,  0, 0, 0, 32'd7,        0);
        vecs[1]  = mk(0, 0, 0, 0,  T_ADD, 0, 1, 2,  32'd5,        2,  32'd0,  0, 0, 0, 32'd5,        0);
        vecs[2]  = mk(1, 1, 2, 3,  T_ADD, 1, 0, 0,  32'd0,        3,  32'd12, 0, 0, 1, 32'd12,       1);
        vecs[3]  = mk(1, 1, 2, 4,  T_SUB, 1, 0, 0,  32'd0,        4,  32'd2,  0, 0, 1, 32'd2,        2);
        vecs[4]  = mk(1, 1, 2, 5,  T_AND, 1, 0, 0,  32'd0,        5,  32'd5,  0, 0, 1, 32'd5,        3);
        vecs[5]  = mk(1, 1, 2, 6,  T_OR,  1, 0, 0,  32'd0,        6,  32'd7,  0, 0, 1, 32'd7,        4);
        vecs[6]  = mk(1, 1, 2, 7,  T_SLT, 1, 0, 0,  32'd0,        7,  32'd0,  1, 0, 1, 32'd0,        5);
        vecs[7]  = mk(1, 2, 1, 7,  T_SLT, 1, 0, 0,  32'd0,        7,  32'd1,  0, 0, 1, 32'd1,        6);
        vecs[8]  = mk(0, 0, 0, 0,  T_ADD, 1, 1, 8,  32'hFFFFFFFF, 8,  32'd1,  0, 0, 0, 32'hFFFFFFFF, 6);
        vecs[9]  = mk(1, 8, 1, 12, T_SLT, 1, 0, 0,  32'd0,        12, 32'd1,  0, 0, 1, 32'd1,        7);
        vecs[10] = mk(0, 0, 0, 0,  T_ADD, 0, 1, 9,  32'hFFFFFFFF, 9,  32'd1,  0, 0, 0, 32'hFFFFFFFF, 7);
        vecs[11] = mk(0, 0, 0, 0,  T_ADD, 0, 1, 10, 32'd1,        10, 32'd1,  0, 0, 0, 32'd1,        7);
        vecs[12] = mk(1, 9, 10, 11, T_ADD, 1, 0, 0, 32'd0,        11, 32'd0,  1, 0, 1, 32'd0,        8);
        vecs[13] = mk(1, 10, 9, 13, T_SUB, 1, 0, 0, 32'd0,        13, 32'd2,  0, 0, 1, 32'd2,        9);
        vecs[14] = mk(1, 1, 2, 0,  T_ADD, 1, 0, 0,  32'd0,        0,  32'd12, 0, 0, 1, 32'd0,        10);
        vecs[15] = mk(1, 1, 2, 3,  T_BAD, 1, 0, 0,  32'd0,        3,  32'd0,  1, 1, 1, 32'd12,       11);
        vecs[16] = mk(1, 1, 1, 3,  T_ADD, 0, 0, 0,  32'd0,        3,  32'd14, 0, 0, 1, 32'd12,       12);
        vecs[17] = mk(1, 1, 2, 3,  T_ADD, 1, 1, 3,  32'd99,       3,  32'd12, 0, 0, 1, 32'd12,       13);
        vecs[18] = mk(1, 1, 1, 3,  T_ADD, 1, 1, 20, 32'd77,       20, 32'd14, 0, 0, 1, 32'd77,       14);
        vecs[19] = mk(1, 3, 3, 14, T_ADD, 1, 0, 0,  32'd0,        14, 32'd28, 0, 0, 1, 32'd28,       15);

        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result_q", result_q, 32'd0);
        chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
        chk("rst_illegal_q", {31'd0, illegal_q}, 32'd0);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_retired_cnt", retired_cnt, 32'd0);
        reset = 0;

        for (int i = 0; i < 20; i++) begin
            instr_valid = vecs[i].iv; rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd;
            ALU_ctrl = vecs[i].ctrl; reg_write = vecs[i].rw;
            init_we = vecs[i].lwe; init_addr = vecs[i].la; init_data = vecs[i].ld;
            dbg_addr = vecs[i].da;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_result_q", i), result_q, vecs[i].e_res);
            chk($sformatf("vec%0d_zero_q", i), {31'd0, zero_q}, {31'd0, vecs[i].e_z});
            chk($sformatf("vec%0d_illegal_q", i), {31'd0, illegal_q}, {31'd0, vecs[i].e_ill});
            chk($sformatf("vec%0d_result_valid", i), {31'd0, result_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("vec%0d_dbg_data", i), dbg_data, vecs[i].e_dbg);
            chk($sformatf("vec%0d_retired_cnt", i), retired_cnt, vecs[i].e_cnt);
        end

        // Reset arriving with a live instruction and a loader write: both must be discarded.
        reset = 1;
        instr_valid = 1; rs = 1; rt = 2; rd = 15; ALU_ctrl = T_ADD; reg_write = 1;
        init_we = 1; init_addr = 16; init_data = 32'd5;
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        chk("midrst_result_q", result_q, 32'd0);
        chk("midrst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_retired_cnt", retired_cnt, 32'd0);
        chk("midrst_illegal_q", {31'd0, illegal_q}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("midrst_reg%0d", a), dbg_data, 32'd0);
        end

        model_reset();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 79) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            rs          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rt          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ALU_ctrl    = 3'($urandom);
            reg_write   = ($urandom_range(0, 4) != 0);
            init_we     = ($urandom_range(0, 2) == 0);
            init_addr   = 5'($urandom_range(0, 9));
            init_data   = rand_data();
            dbg_addr    = 5'($urandom_range(0, 9));
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_result_q", result_q, m_res);
            chk("rnd_zero_q", {31'd0, zero_q}, {31'd0, m_zero});
            chk("rnd_illegal_q", {31'd0, illegal_q}, {31'd0, m_ill});
            chk("rnd_result_valid", {31'd0, result_valid}, {31'd0, m_valid});
            chk("rnd_retired_cnt", retired_cnt, m_cnt);
            chk("rnd_dbg_data", dbg_data, m_regs[dbg_addr]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
